iobus_timer_intr: RTL and testbench
===================================

// Module: iobus_timer_intr
// PURPOSE
//  Memory-mapped interval timer on the OTTER I/O bus, instantiated beside OTTER_TOP.
//  Consumes CPU stores (IOBUS_ADDR/IOBUS_OUT/IOBUS_WR) and returns register reads for the top-level IOBUS_IN mux.
//  Produces the interrupt request wired to OTTER_TOP's INTR input.
//  Closes the loop: software programs a period, the block interrupts the CPU on each expiry.
// PARAMETERS
//  ADDR_CTRL          32'h1100_00D0  control/status register address
//  ADDR_TC            32'h1100_00D4  terminal-count register address
//  ADDR_CNT           32'h1100_00D8  live counter address (R/W)
//  INTR_PULSE_CYCLES  2              INTR high time in CLK cycles (>=1)
// PORTS
//  CLK         in   1   system clock, rising edge
//  RST         in   1   asynchronous reset, active-low (0 = reset)
//  IOBUS_ADDR  in   32  CPU I/O address
//  IOBUS_OUT   in   32  CPU store data
//  IOBUS_WR    in   1   store strobe, 1-cycle, qualifies IOBUS_ADDR/IOBUS_OUT
//  RD_DATA     out  32  read data for selected register, 0 if no hit
//  RD_HIT      out  1   IOBUS_ADDR matches one of the three addresses
//  INTR        out  1   interrupt request to CPU
// BEHAVIOUR
//  Reset: CTRL=0, TC=0, CNT=0, prescale count=0, OVR=0, INTR=0, FSM=I_IDLE. RD_DATA/RD_HIT are combinational.
//  CTRL fields:
//   [0] EN
//   [1] AUTO_RELOAD
//   [15:8] PRESCALE
//   [16] OVR (read-only sticky; write 1 to bit16 clears it)
//   Other bits read 0.
//  Writes: on the edge with IOBUS_WR=1 and address hit, the register loads IOBUS_OUT. Misses are ignored.
//  Writing CTRL clears the prescale counter.
//  Tick: prescale counter runs while EN=1. tick=1 when it equals PRESCALE, then it wraps to 0. Period = PRESCALE+1 cycles.
//  Latency example (PRESCALE=0): EN written at edge 0; first tick at edge 1 (CNT 0->1).
//  On tick:
//   If CNT==TC: CNT<=0 (terminal event). Clear EN unless AUTO_RELOAD=1.
//   Else: CNT<=CNT+1, 32-bit wrap.
//   TC=0 gives a terminal event every tick.
//  EN=0 holds CNT. A write to ADDR_CNT in the same cycle as a tick wins: CNT<=IOBUS_OUT, no terminal event.
//  INTR FSM:
//   I_IDLE --terminal--> I_ACTIVE: INTR=1 registered at the terminal edge, pulse counter <= INTR_PULSE_CYCLES-1.
//   I_ACTIVE: decrement the pulse counter; at 0 and no new terminal event -> I_IDLE, INTR=0.
//   Terminal event in I_ACTIVE: set OVR, reload pulse counter (pulse stretches, no gap).
//  Clearing EN mid-pulse: the pulse completes normally.
//  RST low mid-operation: all state returns to reset values immediately. INTR drops asynchronously.
//  Reads: RD_DATA = CTRL/TC/CNT by address (current register value, not the value being written this cycle).
// CONFIGURATION
//  IOTIMER_LEVEL_INTR_EN defined:
//   INTR is a level. Set on a terminal event; held until a CTRL write with bit17=1 (ack), which clears it at that edge.
//   INTR_PULSE_CYCLES is unused.
//   Terminal event while INTR=1 sets OVR.
//   Ack in the same cycle as a terminal event: INTR stays 1.
//  Not defined: pulse behaviour as above. Bit17 is ignored.
// TESTING
//  1. Release RST; idle 10 cycles -> INTR=0; RD_DATA at ADDR_CTRL/TC/CNT = 0, RD_HIT=1.
//  2. TC=3, CTRL=0x3 (EN, AUTO_RELOAD, PRESCALE=0) -> CNT 1,2,3,0 on successive edges;
//     INTR high 2 cycles starting after edge 4; repeats every 4 cycles.
//  3. TC=1, CTRL=0x0401 (PRESCALE=4, one-shot) -> one INTR pulse 10 cycles after the write;
//     CTRL[0] reads 0 afterwards, CNT=0.
//  4. TC=0, PRESCALE=0, AUTO_RELOAD, INTR_PULSE_CYCLES=2 -> INTR stays high continuously;
//     OVR=1; writing CTRL with bit16=1 clears OVR (it re-sets next event).
//  5. Write ADDR_CNT=7 in a tick cycle with TC=5 -> CNT=7, no INTR; CNT keeps incrementing past TC and wraps at 2^32.
//  6. Drop RST mid-pulse -> INTR=0 same cycle; all registers read 0.
//     With IOTIMER_LEVEL_INTR_EN: INTR holds until a CTRL write with bit17=1.

Source files
------------

// File: rtl/iobus_timer_intr.sv
// iobus_timer_intr: memory-mapped interval timer on the OTTER I/O bus.
// The CPU programs a terminal count, a prescaler and an enable.
// The counter advances once per prescaled tick.
// Each terminal event raises INTR toward the CPU.
// Optional build macro IOTIMER_LEVEL_INTR_EN: INTR becomes a level that
// software acknowledges by writing CTRL with bit17=1. Without the macro,
// INTR is a fixed-width pulse of INTR_PULSE_CYCLES clocks.
module iobus_timer_intr #(
   parameter logic [31:0] ADDR_CTRL         = 32'h1100_00D0,
   parameter logic [31:0] ADDR_TC           = 32'h1100_00D4,
   parameter logic [31:0] ADDR_CNT          = 32'h1100_00D8,
   parameter int          INTR_PULSE_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] RD_DATA,
   output logic        RD_HIT,
   output logic        INTR
);

   typedef enum logic {I_IDLE, I_ACTIVE} istate_t;

   // Register file: CTRL fields, terminal count, live counter, prescale divider
   logic        en_q, en_d;
   logic        ar_q, ar_d;
   logic [7:0]  prescale_q, prescale_d;
   logic        ovr_q, ovr_d;
   logic [31:0] tc_q, tc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  div_q, div_d;

   istate_t     state_q, state_d;

   logic hit_ctrl, hit_tc, hit_cnt;
   logic wr_ctrl, wr_tc, wr_cnt;
   logic tick, term, ovr_set;

   assign hit_ctrl = (IOBUS_ADDR == ADDR_CTRL);
   assign hit_tc   = (IOBUS_ADDR == ADDR_TC);
   assign hit_cnt  = (IOBUS_ADDR == ADDR_CNT);

   assign wr_ctrl  = IOBUS_WR & hit_ctrl;
   assign wr_tc    = IOBUS_WR & hit_tc;
   assign wr_cnt   = IOBUS_WR & hit_cnt;

   // A tick fires on the cycle the divider reaches PRESCALE, giving a period of PRESCALE+1
   assign tick    = en_q & (div_q == prescale_q);
   // A CPU store to CNT overrides the tick, so no terminal event can happen that cycle
   assign term    = tick & ~wr_cnt & (cnt_q == tc_q);
   // A terminal event that lands while INTR is already asserted is an overrun
   assign ovr_set = term & (state_q == I_ACTIVE);

   // Combinational read-back of the current (pre-write) register values
   always_comb begin
      RD_DATA = 32'd0;
      RD_HIT  = 1'b0;
      if (hit_ctrl) begin
         RD_DATA = {15'd0, ovr_q, prescale_q, 6'd0, ar_q, en_q};
         RD_HIT  = 1'b1;
      end else if (hit_tc) begin
         RD_DATA = tc_q;
         RD_HIT  = 1'b1;
      end else if (hit_cnt) begin
         RD_DATA = cnt_q;
         RD_HIT  = 1'b1;
      end
   end

   // Next-state for the timer registers; CPU stores are applied last so they take priority
   always_comb begin
      en_d       = en_q;
      ar_d       = ar_q;
      prescale_d = prescale_q;
      ovr_d      = ovr_q;
      tc_d       = tc_q;
      cnt_d      = cnt_q;
      div_d      = div_q;

      if (en_q) begin
         div_d = tick ? 8'd0 : div_q + 8'd1;
      end

      if (tick) begin
         if (term) begin
            cnt_d = 32'd0;
            if (!ar_q) begin
               en_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + 32'd1;
         end
      end

      if (ovr_set) begin
         ovr_d = 1'b1;
      end

      if (wr_cnt) begin
         cnt_d = IOBUS_OUT;
      end

      if (wr_tc) begin
         tc_d = IOBUS_OUT;
      end

      // Writing CTRL restarts the prescale phase; a write-1 to bit16 clears OVR
      // even if an overrun is flagged on the same edge.
      if (wr_ctrl) begin
         en_d       = IOBUS_OUT[0];
         ar_d       = IOBUS_OUT[1];
         prescale_d = IOBUS_OUT[15:8];
         div_d      = 8'd0;
         if (IOBUS_OUT[16]) begin
            ovr_d = 1'b0;
         end
      end
   end

   // Timer register update with asynchronous active-low reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         en_q       <= 1'b0;
         ar_q       <= 1'b0;
         prescale_q <= 8'd0;
         ovr_q      <= 1'b0;
         tc_q       <= 32'd0;
         cnt_q      <= 32'd0;
         div_q      <= 8'd0;
      end else begin
         en_q       <= en_d;
         ar_q       <= ar_d;
         prescale_q <= prescale_d;
         ovr_q      <= ovr_d;
         tc_q       <= tc_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
      end
   end

`ifdef IOTIMER_LEVEL_INTR_EN
   logic ack;

   // Software acknowledge: a CTRL store with bit17 set
   assign ack = wr_ctrl & IOBUS_OUT[17];

   // Level interrupt: raised by a terminal event, held until acked; a same-cycle event wins over the ack
   always_comb begin
      state_d = state_q;
      case (state_q)
         I_IDLE: begin
            if (term) begin
               state_d = I_ACTIVE;
            end
         end
         I_ACTIVE: begin
            if (ack && !term) begin
               state_d = I_IDLE;
            end
         end
         default: state_d = I_IDLE;
      endcase
   end

   // Interrupt state register; reset drops INTR immediately
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= I_IDLE;
      end else begin
         state_q <= state_d;
      end
   end
`else
   localparam int             PW         = (INTR_PULSE_CYCLES > 1) ? $clog2(INTR_PULSE_CYCLES) : 1;
   localparam logic [PW-1:0]  PULSE_LOAD = PW'(INTR_PULSE_CYCLES - 1);

   logic [PW-1:0] pcnt_q, pcnt_d;

   // Pulse interrupt: each terminal event (re)loads the width counter, so back-to-back events stretch the pulse
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      case (state_q)
         I_IDLE: begin
            if (term) begin
               state_d = I_ACTIVE;
               pcnt_d  = PULSE_LOAD;
            end
         end
         I_ACTIVE: begin
            if (term) begin
               pcnt_d = PULSE_LOAD;
            end else if (pcnt_q == '0) begin
               state_d = I_IDLE;
            end else begin
               pcnt_d = pcnt_q - 1'b1;
            end
         end
         default: state_d = I_IDLE;
      endcase
   end

   // Interrupt state and pulse-width counter; reset drops INTR immediately
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= I_IDLE;
         pcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
      end
   end
`endif

   assign INTR = (state_q == I_ACTIVE);

endmodule

// File: tb/tb_iobus_timer_intr.sv
// Self-checking bench for iobus_timer_intr (default pulse-mode build).
module tb_iobus_timer_intr;

   localparam logic [31:0] A_CTRL = 32'h1100_00D0;
   localparam logic [31:0] A_TC   = 32'h1100_00D4;
   localparam logic [31:0] A_CNT  = 32'h1100_00D8;
   localparam logic [31:0] A_MISS = 32'h1100_00DC;
   localparam int          PULSE  = 2;

   logic        CLK;
   logic        RST;
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] RD_DATA;
   logic        RD_HIT;
   logic        INTR;

   int checks = 0;
   int errors = 0;

   iobus_timer_intr #(
      .ADDR_CTRL(A_CTRL), .ADDR_TC(A_TC), .ADDR_CNT(A_CNT), .INTR_PULSE_CYCLES(PULSE)
   ) dut (
      .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
      .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA), .RD_HIT(RD_HIT), .INTR(INTR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: register contents plus "cycles of INTR high still owed"
   logic        m_en, m_ar, m_ovr;
   logic [7:0]  m_ps, m_div;
   logic [31:0] m_tc, m_cnt;
   int          m_rem;

   function automatic void model_reset();
      m_en = 0; m_ar = 0; m_ovr = 0; m_ps = 0; m_div = 0;
      m_tc = 0; m_cnt = 0; m_rem = 0;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a == A_CTRL) return {15'd0, m_ovr, m_ps, 6'd0, m_ar, m_en};
      if (a == A_TC)   return m_tc;
      if (a == A_CNT)  return m_cnt;
      return 32'd0;
   endfunction

   function automatic void model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
      bit tick, term, wcnt;
      tick = m_en && (m_div == m_ps);
      wcnt = wr && (a == A_CNT);
      term = tick && !wcnt && (m_cnt == m_tc);
      if (term && m_rem > 0) m_ovr = 1;
      if (term) m_rem = PULSE;
      else if (m_rem > 0) m_rem = m_rem - 1;
      if (m_en) m_div = tick ? 8'd0 : m_div + 8'd1;
      if (tick) m_cnt = term ? 32'd0 : m_cnt + 32'd1;
      if (term && !m_ar) m_en = 0;
      if (wcnt) m_cnt = d;
      if (wr && a == A_TC) m_tc = d;
      if (wr && a == A_CTRL) begin
         m_en = d[0]; m_ar = d[1]; m_ps = d[15:8]; m_div = 0;
         if (d[16]) m_ovr = 0;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive a bus cycle and move to the sampling point (falling edge)
   task automatic apply(input logic wr, input logic [31:0] a, input logic [31:0] d);
      IOBUS_WR = wr; IOBUS_ADDR = a; IOBUS_OUT = d;
      @(negedge CLK);
   endtask

   // Commit the driven cycle at the rising edge and keep the model in step
   task automatic clock_in();
      model_step(IOBUS_WR, IOBUS_ADDR, IOBUS_OUT);
      @(posedge CLK);
      #1;
      IOBUS_WR = 1'b0;
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      apply(1'b1, a, d);
      clock_in();
   endtask

   task automatic do_reset();
      RST = 1'b0; IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      model_reset();
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      logic        exp_hit;
      logic        exp_intr;
   } vec_t;

   vec_t tbl [22];
   logic [31:0] addrs [4];

   initial begin
      int n, w, hi;
      addrs[0] = A_CTRL; addrs[1] = A_TC; addrs[2] = A_CNT; addrs[3] = A_MISS;

      // Free-running auto-reload with TC=3, PRESCALE=0, then disable mid-pulse
      tbl = '{
         '{1'b0, A_CTRL, 32'h0, 32'h0, 1'b1, 1'b0},
         '{1'b0, A_TC,   32'h0, 32'h0, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h0, 1'b1, 1'b0},
         '{1'b1, A_TC,   32'h3, 32'h0, 1'b1, 1'b0},
         '{1'b0, A_TC,   32'h0, 32'h3, 1'b1, 1'b0},
         '{1'b1, A_CTRL, 32'h3, 32'h0, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h0, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h1, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h2, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h3, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h0, 1'b1, 1'b1},
         '{1'b0, A_CNT,  32'h0, 32'h1, 1'b1, 1'b1},
         '{1'b0, A_CNT,  32'h0, 32'h2, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h3, 1'b1, 1'b0},
         '{1'b0, A_CNT,  32'h0, 32'h0, 1'b1, 1'b1},
         '{1'b0, A_CNT,  32'h0, 32'h1, 1'b1, 1'b1},
         '{1'b0, A_CTRL, 32'h0, 32'h3, 1'b1, 1'b0},
         '{1'b0, A_MISS, 32'h0, 32'h0, 1'b0, 1'b0},
         '{1'b1, A_CTRL, 32'h0, 32'h3, 1'b1, 1'b1},
         '{1'b0, A_CNT,  32'h0, 32'h1, 1'b1, 1'b1},
         '{1'b0, A_CNT,  32'h0, 32'h1, 1'b1, 1'b0},
         '{1'b0, A_CTRL, 32'h0, 32'h0, 1'b1, 1'b0}
      };

      do_reset();

      // Idle after reset: everything reads zero, no interrupt
      for (int i = 0; i < 10; i++) begin
         apply(1'b0, addrs[i % 3], 32'd0);
         chk("idle_rd", RD_DATA, 32'd0);
         chk("idle_hit", {31'd0, RD_HIT}, 32'd1);
         chk("idle_intr", {31'd0, INTR}, 32'd0);
         clock_in();
      end

      for (int i = 0; i < 22; i++) begin
         apply(tbl[i].wr, tbl[i].addr, tbl[i].data);
         chk($sformatf("tbl%0d_rd", i), RD_DATA, tbl[i].exp_rd);
         chk($sformatf("tbl%0d_hit", i), {31'd0, RD_HIT}, {31'd0, tbl[i].exp_hit});
         chk($sformatf("tbl%0d_intr", i), {31'd0, INTR}, {31'd0, tbl[i].exp_intr});
         clock_in();
      end

      // One-shot with PRESCALE=4, TC=1: pulse 10 edges after the CTRL write
      do_reset();
      wr_reg(A_TC, 32'd1);
      wr_reg(A_CTRL, 32'h0000_0401);
      n = 1;
      while (n <= 40) begin
         @(posedge CLK); #1;
         if (INTR) break;
         n++;
      end
      chk("oneshot_delay", n, 10);
      w = 1;
      for (int k = 0; k < 10; k++) begin
         @(posedge CLK); #1;
         if (!INTR) break;
         w++;
      end
      chk("oneshot_width", w, PULSE);
      hi = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge CLK); #1;
         if (INTR) hi++;
      end
      chk("oneshot_no_repeat", hi, 0);
      IOBUS_ADDR = A_CTRL; #1;
      chk("oneshot_ctrl", RD_DATA, 32'h0000_0400);
      IOBUS_ADDR = A_CNT; #1;
      chk("oneshot_cnt", RD_DATA, 32'd0);

      // TC=0 auto-reload: continuous INTR, overrun flag, clear-on-write
      do_reset();
      wr_reg(A_TC, 32'd0);
      wr_reg(A_CTRL, 32'h0000_0003);
      repeat (3) @(posedge CLK);
      #1;
      hi = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge CLK); #1;
         if (INTR) hi++;
      end
      chk("cont_intr_high", hi, 8);
      IOBUS_ADDR = A_CTRL; #1;
      chk("cont_ovr_set", RD_DATA, 32'h0001_0003);
      wr_reg(A_CTRL, 32'h0001_0003);
      IOBUS_ADDR = A_CTRL; #1;
      chk("ovr_cleared", RD_DATA, 32'h0000_0003);
      chk("cont_intr_after_clr", {31'd0, INTR}, 32'd1);
      @(posedge CLK); #1;
      chk("ovr_reset_next", RD_DATA, 32'h0001_0003);

      // Asynchronous reset while INTR is high
      @(posedge CLK); #2;
      RST = 1'b0;
      #1;
      chk("rst_intr", {31'd0, INTR}, 32'd0);
      IOBUS_ADDR = A_CTRL; #1;
      chk("rst_ctrl", RD_DATA, 32'd0);
      IOBUS_ADDR = A_TC; #1;
      chk("rst_tc", RD_DATA, 32'd0);
      IOBUS_ADDR = A_CNT; #1;
      chk("rst_cnt", RD_DATA, 32'd0);
      do_reset();

      // CNT write in a tick cycle wins; counting runs past TC and wraps at 2^32
      wr_reg(A_TC, 32'd5);
      wr_reg(A_CTRL, 32'h0000_0001);
      repeat (2) @(posedge CLK);
      #1;
      wr_reg(A_CNT, 32'd7);
      IOBUS_ADDR = A_CNT; #1;
      chk("cntwr_value", RD_DATA, 32'd7);
      for (int k = 1; k <= 6; k++) begin
         @(posedge CLK); #1;
         chk("cnt_past_tc", RD_DATA, 32'd7 + 32'(k));
         chk("cnt_no_intr", {31'd0, INTR}, 32'd0);
      end
      wr_reg(A_CNT, 32'hFFFF_FFFE);
      IOBUS_ADDR = A_CNT; #1;
      @(posedge CLK); #1;
      chk("wrap_ffff", RD_DATA, 32'hFFFF_FFFF);
      @(posedge CLK); #1;
      chk("wrap_zero", RD_DATA, 32'd0);
      @(posedge CLK); #1;
      chk("wrap_one", RD_DATA, 32'd1);
      chk("wrap_no_intr", {31'd0, INTR}, 32'd0);

      // Randomized traffic against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a, d;
         int r;
         r = $urandom_range(0, 9);
         a = addrs[$urandom_range(0, 3)];
         d = $urandom;
         if (r < 2) begin
            if (a == A_CTRL)
               d = {14'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 3)), 6'd0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0)};
            else if (a == A_TC)
               d = 32'($urandom_range(0, 6));
            else if (a == A_CNT)
               d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 6));
            apply(1'b1, a, d);
         end else begin
            apply(1'b0, a, d);
         end
         chk("rand_rd", RD_DATA, model_read(a));
         chk("rand_hit", {31'd0, RD_HIT}, {31'd0, (a != A_MISS)});
         chk("rand_intr", {31'd0, INTR}, {31'd0, (m_rem > 0)});
         clock_in();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
